bram_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences an external simple dual-port BRAM. The BRAM has write port A and an enable-gated read port B with a registered output. The controller owns the write/read pointers and the occupancy count, and drives both BRAM ports. It exposes valid/ready streaming interfaces on the write and read sides. The read side is first-word-fall-through: BRAM port-B output data is presented directly as the FIFO head. It is instantiated beside the BRAM wherever a buffered stream crosses between blocks in the same clock domain.

---
 rtl/bram_fifo_ctrl.sv | 111 +++++++++++
 tb/tb_bram_fifo_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl
//   Single-clock FIFO controller for an external simple dual-port BRAM.
//   Port A is the write port. Port B is an enable-gated read port with a
//   registered output. The controller keeps the write and read pointers and
//   the occupancy, and drives both BRAM ports. The read side is
//   first-word-fall-through: the BRAM port-B output is the FIFO head directly.
//
// Ports
//   clk_i, rst_i        clock and synchronous active-high reset
//   s_data_i/valid/ready  write-side stream
//   m_data_o/valid/ready  read-side stream (head = ram_data_b_i)
//   count_o             words held: BRAM words not yet fetched, plus the head
//   afull_o             count_o >= AFULL_LEVEL
//   ram_*_a_o           BRAM write port (addr, data, we)
//   ram_*_b_o, ram_data_b_i  BRAM read port (addr, en, registered data)
module bram_fifo_ctrl #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10,
  parameter int AFULL_LEVEL   = 2**RAM_ADDR_BITS - 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [RAM_WIDTH-1:0]     s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [RAM_WIDTH-1:0]     m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [RAM_ADDR_BITS:0]   count_o,
  output logic                     afull_o,
  output logic [RAM_ADDR_BITS-1:0] ram_addr_a_o,
  output logic [RAM_WIDTH-1:0]     ram_data_a_o,
  output logic                     ram_we_a_o,
  output logic [RAM_ADDR_BITS-1:0] ram_addr_b_o,
  output logic                     ram_en_b_o,
  input  logic [RAM_WIDTH-1:0]     ram_data_b_i
);

  localparam logic [RAM_ADDR_BITS:0] DEPTH_C = (RAM_ADDR_BITS+1)'(1) << RAM_ADDR_BITS;
  localparam logic [RAM_ADDR_BITS:0] AFULL_C = (RAM_ADDR_BITS+1)'(AFULL_LEVEL);
  localparam logic [RAM_ADDR_BITS:0] ZERO_C  = '0;

  typedef enum logic {EMPTY = 1'b0, VALID = 1'b1} head_e;

  logic [RAM_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [RAM_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [RAM_ADDR_BITS:0]   ram_cnt_q, ram_cnt_d;
  head_e                    head_q, head_d;

  logic push, pop, fetch;

  assign m_valid_o = (head_q == VALID);
  assign s_ready_o = !rst_i && (ram_cnt_q != DEPTH_C);
  assign push      = s_valid_i && s_ready_o;
  assign pop       = m_valid_o && m_ready_i;
  // Port B is only read when the head slot is free or being consumed, so the
  // registered BRAM output (the head) never changes under a stall.
  assign fetch     = !rst_i && (ram_cnt_q != ZERO_C) && (!m_valid_o || m_ready_i);

  assign ram_addr_a_o = wr_ptr_q;
  assign ram_data_a_o = s_data_i;
  assign ram_we_a_o   = push;
  assign ram_addr_b_o = rd_ptr_q;
  assign ram_en_b_o   = fetch;
  assign m_data_o     = ram_data_b_i;

  assign count_o = ram_cnt_q + {{RAM_ADDR_BITS{1'b0}}, m_valid_o};
  assign afull_o = (count_o >= AFULL_C);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    head_d    = head_q;
    if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (fetch) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, fetch})
      2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
      2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
      default: ram_cnt_d = ram_cnt_q;
    endcase
    case (head_q)
      EMPTY:   if (fetch) head_d = VALID;
      VALID:   if (pop && !fetch) head_d = EMPTY;
      default: head_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      head_q    <= EMPTY;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      head_q    <= head_d;
    end
  end

`ifndef SYNTHESIS
  a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i) ram_cnt_q <= DEPTH_C);
  a_no_fetch_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    (ram_cnt_q == ZERO_C) |-> !fetch);
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    (ram_cnt_q == DEPTH_C) |-> !push);
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
module tb_bram_fifo_ctrl;
  localparam int W  = 8;
  localparam int AB = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [W-1:0]  s_data_i;
  logic          s_valid_i, s_ready_o;
  logic [W-1:0]  m_data_o;
  logic          m_valid_o, m_ready_i;
  logic [AB:0]   count_o;
  logic          afull_o;
  logic [AB-1:0] ram_addr_a_o, ram_addr_b_o;
  logic [W-1:0]  ram_data_a_o, ram_data_b_i;
  logic          ram_we_a_o, ram_en_b_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bram_fifo_ctrl #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .AFULL_LEVEL(3)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .count_o(count_o), .afull_o(afull_o),
    .ram_addr_a_o(ram_addr_a_o), .ram_data_a_o(ram_data_a_o), .ram_we_a_o(ram_we_a_o),
    .ram_addr_b_o(ram_addr_b_o), .ram_en_b_o(ram_en_b_o), .ram_data_b_i(ram_data_b_i)
  );

  // simple dual-port BRAM model with registered read
  logic [W-1:0] mem [4];
  always @(posedge clk) begin
    if (ram_we_a_o) mem[ram_addr_a_o] <= ram_data_a_o;
    if (ram_en_b_o) ram_data_b_i <= mem[ram_addr_b_o];
  end

  // inputs change 1 unit after the rising edge; outputs are sampled on the falling edge
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; s_valid_i = 1'b1; s_data_i = 8'hEE; m_ready_i = 1'b1;
    next_cycle(); next_cycle();
    @(negedge clk);
    n_chk++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got %b exp 0", s_ready_o); end
    n_chk++; if (ram_we_a_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", ram_we_a_o); end
    n_chk++; if (ram_en_b_o !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b exp 0", ram_en_b_o); end
    next_cycle();
    rst_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0;
    @(negedge clk);
    n_chk++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count_o); end
    n_chk++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b exp 0", m_valid_o); end
    n_chk++; if (afull_o !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b exp 0", afull_o); end
    n_chk++; if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_s_ready got %b exp 1", s_ready_o); end
    next_cycle();
  endtask

  task automatic test_single_word();
    logic [AB:0] exp_cnt [4];
    exp_cnt[0] = 3'd0; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd1; exp_cnt[3] = 3'd0;
    m_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_valid_i = (k == 0); s_data_i = 8'hA5;
      @(negedge clk);
      n_chk++; if (count_o !== exp_cnt[k]) begin n_fail++; $display("FAIL single_count c%0d got %0d exp %0d", k, count_o, exp_cnt[k]); end
      n_chk++; if (m_valid_o !== (k == 2)) begin n_fail++; $display("FAIL single_valid c%0d got %b exp %b", k, m_valid_o, k == 2); end
      if (k == 2) begin
        n_chk++; if (m_data_o !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h exp a5", m_data_o); end
      end
      next_cycle();
    end
  endtask

  task automatic test_fill();
    logic [W-1:0] d = 8'h01;
    int acc = 0;
    s_valid_i = 1'b1; m_ready_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s_data_i = d;
      @(negedge clk);
      n_chk++; if (afull_o !== (count_o >= 3'd3)) begin n_fail++; $display("FAIL fill_afull c%0d got %b count %0d", k, afull_o, count_o); end
      if (s_ready_o) begin acc++; d++; end
      next_cycle();
    end
    s_valid_i = 1'b0;
    @(negedge clk);
    n_chk++; if (acc != 5) begin n_fail++; $display("FAIL fill_accepted got %0d exp 5", acc); end
    n_chk++; if (count_o !== 3'd5) begin n_fail++; $display("FAIL fill_count got %0d exp 5", count_o); end
    n_chk++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_s_ready got %b exp 0", s_ready_o); end
    n_chk++; if (afull_o !== 1'b1) begin n_fail++; $display("FAIL fill_afull_end got %b exp 1", afull_o); end
    n_chk++; if (m_valid_o !== 1'b1 || m_data_o !== 8'h01) begin n_fail++; $display("FAIL fill_head got v%b %h exp v1 01", m_valid_o, m_data_o); end
    n_chk++; if (ram_en_b_o !== 1'b0) begin n_fail++; $display("FAIL fill_en got %b exp 0", ram_en_b_o); end
    next_cycle();
  endtask

  task automatic test_drain();
    m_ready_i = 1'b1; s_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++; if (m_valid_o !== 1'b1 || m_data_o !== W'(k + 1)) begin n_fail++; $display("FAIL drain_data c%0d got v%b %h exp v1 %h", k, m_valid_o, m_data_o, k + 1); end
      next_cycle();
    end
    @(negedge clk);
    n_chk++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %b exp 0", m_valid_o); end
    n_chk++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL drain_count got %0d exp 0", count_o); end
    n_chk++; if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL drain_s_ready got %b exp 1", s_ready_o); end
    next_cycle();
  endtask

  task automatic test_streaming();
    m_ready_i = 1'b1;
    for (int k = 0; k < 23; k++) begin
      s_valid_i = (k < 20); s_data_i = W'(8'h10 + k);
      @(negedge clk);
      if (k >= 2 && k < 22) begin
        n_chk++; if (m_valid_o !== 1'b1 || m_data_o !== W'(8'h10 + k - 2)) begin n_fail++; $display("FAIL stream_data c%0d got v%b %h exp v1 %h", k, m_valid_o, m_data_o, 8'h10 + k - 2); end
      end else begin
        n_chk++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_idle c%0d got v%b exp 0", k, m_valid_o); end
      end
      if (k >= 2 && k <= 20) begin
        n_chk++; if (count_o !== 3'd2) begin n_fail++; $display("FAIL stream_count c%0d got %0d exp 2", k, count_o); end
      end
      next_cycle();
    end
    s_valid_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] q [$];
    logic [W-1:0] d = 8'h40;
    logic [W-1:0] prev_d = '0;
    logic stalled = 1'b0;
    int guard = 0;
    for (int k = 0; k < 80; k++) begin
      s_valid_i = ($urandom_range(0, 3) != 0);
      m_ready_i = $urandom_range(0, 1) != 0;
      s_data_i = d;
      @(negedge clk);
      if (m_valid_o) begin
        n_chk++; if (q.size() == 0 || m_data_o !== q[0]) begin n_fail++; $display("FAIL bp_data c%0d got %h exp %h", k, m_data_o, q.size() ? q[0] : 8'hxx); end
        if (!m_ready_i) begin
          n_chk++; if (ram_en_b_o !== 1'b0) begin n_fail++; $display("FAIL bp_en c%0d got %b exp 0", k, ram_en_b_o); end
        end
      end
      if (stalled) begin
        n_chk++; if (m_data_o !== prev_d) begin n_fail++; $display("FAIL bp_stable c%0d got %h exp %h", k, m_data_o, prev_d); end
      end
      stalled = m_valid_o && !m_ready_i;
      prev_d = m_data_o;
      if (m_valid_o && m_ready_i && q.size() != 0) void'(q.pop_front());
      if (s_valid_i && s_ready_o) begin q.push_back(d); d++; end
      next_cycle();
    end
    s_valid_i = 1'b0; m_ready_i = 1'b1;
    while (guard < 30) begin
      @(negedge clk);
      if (!m_valid_o && q.size() == 0) break;
      if (m_valid_o) begin
        n_chk++; if (q.size() == 0 || m_data_o !== q[0]) begin n_fail++; $display("FAIL bp_drain got %h exp %h", m_data_o, q.size() ? q[0] : 8'hxx); end
        if (q.size() != 0) void'(q.pop_front());
      end
      next_cycle();
      guard++;
    end
    n_chk++; if (guard >= 30 || q.size() != 0) begin n_fail++; $display("FAIL bp_drain_timeout left %0d exp 0", q.size()); end
    n_chk++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL bp_end_count got %0d exp 0", count_o); end
    next_cycle();
  endtask

  task automatic test_reset_mid_run();
    m_ready_i = 1'b0; s_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin s_data_i = W'(8'h71 + k); next_cycle(); end
    s_valid_i = 1'b0;
    @(negedge clk);
    n_chk++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d exp 3", count_o); end
    next_cycle();
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk);
    n_chk++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d exp 0", count_o); end
    n_chk++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", m_valid_o); end
    next_cycle();
    m_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_valid_i = (k == 0); s_data_i = 8'h3C;
      @(negedge clk);
      n_chk++; if (m_valid_o !== (k == 2)) begin n_fail++; $display("FAIL mid_out_valid c%0d got %b exp %b", k, m_valid_o, k == 2); end
      if (k == 2) begin
        n_chk++; if (m_data_o !== 8'h3C) begin n_fail++; $display("FAIL mid_out_data got %h exp 3c", m_data_o); end
      end
      next_cycle();
    end
  endtask

  initial begin
    rst_i = 1'b1; s_valid_i = 1'b0; s_data_i = '0; m_ready_i = 1'b0;
    test_reset();
    test_single_word();
    test_fill();
    test_drain();
    test_streaming();
    test_backpressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
